register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 70 +++++++
 tb/tb_register_file.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x N register file, one write port, two combinational read ports, x00 hardwired to zero.
// Optional write-through forwarding to the read ports when REGISTER_FILE_BYPASS_EN is defined.
module register_file #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    logic [N-1:0] regs [1:31];
    logic [31:0]  wr_sel;
    logic [N-1:0] rd_mem0;
    logic [N-1:0] rd_mem1;

    // One-hot decode; with wr_ena low the select is all-zero whatever wr_addr holds.
    always_comb begin
        wr_sel = '0;
        if (wr_ena == 1'b1) begin
            wr_sel = 32'd1 << wr_addr;
        end
    end

    for (genvar i = 1; i < 32; i++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs[i] <= '0;
            end else if (wr_sel[i]) begin
                regs[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_mem0 = '0;
        rd_mem1 = '0;
        for (int i = 1; i < 32; i++) begin
            if (rd_addr0 == 5'(i)) begin
                rd_mem0 = regs[i];
            end
            if (rd_addr1 == 5'(i)) begin
                rd_mem1 = regs[i];
            end
        end
    end

`ifdef REGISTER_FILE_BYPASS_EN
    logic byp0;
    logic byp1;

    always_comb begin
        byp0 = wr_ena && (wr_addr != 5'd0) && (rd_addr0 == wr_addr);
        byp1 = wr_ena && (wr_addr != 5'd0) && (rd_addr1 == wr_addr);
        rd_data0 = rst ? '0 : (byp0 ? wr_data : rd_mem0);
        rd_data1 = rst ? '0 : (byp1 ? wr_data : rd_mem1);
    end
`else
    always_comb begin
        rd_data0 = rst ? '0 : rd_mem0;
        rd_data1 = rst ? '0 : rd_mem1;
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file with N=5.
`timescale 1ns/1ps
module tb_register_file;

    logic       clk;
    logic       rst;
    logic       wr_ena;
    logic [4:0] wr_addr;
    logic [4:0] wr_data;
    logic [4:0] rd_addr0;
    logic [4:0] rd_data0;
    logic [4:0] rd_addr1;
    logic [4:0] rd_data1;

    int total;
    int bad;

    register_file #(.N(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [4:0] d);
        @(negedge clk);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_ena  = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        wr_ena   = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 5'd0;
        rd_addr0 = 5'd5;
        rd_addr1 = 5'd0;
        #1;
        check("reset_rd0", rd_data0, 5'd0);
        check("reset_rd1", rd_data1, 5'd0);

        @(negedge clk);
        rst = 1'b0;

        // Fill index i with value i.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 5'(i));
        end
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #0.1;
            check("sweep_rd0", rd_data0, 5'(i));
            check("sweep_rd1", rd_data1, 5'(31 - i));
        end

        // Writes to x00 are dropped and alias nowhere.
        write_reg(5'd0, 5'b11111);
        @(negedge clk);
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd0;
        #1;
        check("x00_rd0", rd_data0, 5'd0);
        check("x00_rd1", rd_data1, 5'd0);
        rd_addr0 = 5'd31;
        #1;
        check("x00_no_alias", rd_data0, 5'd31);

        // Same-cycle read-after-write on index 7.
        write_reg(5'd7, 5'd3);
        @(negedge clk);
        rd_addr0 = 5'd7;
        wr_ena   = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 5'd9;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        check("raw_before_edge", rd_data0, 5'd9);
`else
        check("raw_before_edge", rd_data0, 5'd3);
`endif
        @(posedge clk);
        #1;
        wr_ena = 1'b0;
        check("raw_after_edge", rd_data0, 5'd9);

        // wr_ena gating, including unknown address/data while disabled.
        @(negedge clk);
        wr_ena  = 1'b0;
        wr_addr = 5'd12;
        wr_data = 5'd21;
        repeat (4) @(posedge clk);
        @(negedge clk);
        wr_addr = 'x;
        wr_data = 'x;
        repeat (2) @(posedge clk);
        #1;
        rd_addr0 = 5'd12;
        rd_addr1 = 5'd12;
        #1;
        check("gate_idx12_rd0", rd_data0, 5'd12);
        check("gate_idx12_rd1", rd_data1, 5'd12);
        wr_addr = 5'd0;
        wr_data = 5'd0;

        // Asynchronous reset with loaded registers, swept before any clock edge.
        write_reg(5'd31, 5'd17);
        @(negedge clk);
        rd_addr0 = 5'd31;
        #1;
        check("pre_rst_idx31", rd_data0, 5'd17);
        wr_ena  = 1'b1;
        wr_addr = 5'd9;
        wr_data = 5'd1;
        rst     = 1'b1;
        #0.5;
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(i);
            #0.1;
            check("rst_sweep_rd0", rd_data0, 5'd0);
            check("rst_sweep_rd1", rd_data1, 5'd0);
        end
        wr_addr = 5'd31;
        wr_data = 5'd17;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        wr_ena = 1'b0;
        rd_addr0 = 5'd31;
        rd_addr1 = 5'd9;
        #1;
        check("rst_edge_write_dropped", rd_data0, 5'd0);
        check("rst_edge_write9_dropped", rd_data1, 5'd0);
        rd_addr1 = 5'd7;
        #1;
        check("rst_cleared_idx7", rd_data1, 5'd0);

        write_reg(5'd31, 5'd5);
        #1;
        check("post_rst_write", rd_data0, 5'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
